// File: rtl/liang_pkg.sv
// Shared core types: decode record, opcode constants and IDU buffer entry.
package liang_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned REG_AW = 5;

   typedef logic [XLEN-1:0]   pc_t;
   typedef logic [31:0]       inst_t;
   typedef logic [REG_AW-1:0] reg_idx_t;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;

   localparam logic [6:0] F7_ZERO = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [3:0] {
      OP_NONE, OP_ALR, OP_ALI, OP_BRANCH, OP_LOAD, OP_STORE,
      OP_JAL, OP_JALR, OP_AUIPC, OP_LUI
   } fu_op_t;

   typedef enum logic [1:0] {FU_NONE, FU_ALU, FU_LSU, FU_MFPU} fu_t;

   typedef enum logic [4:0] {
      FUNC_NONE,
      FUNC_ADD, FUNC_SUB, FUNC_SLL, FUNC_SLT, FUNC_SLTU,
      FUNC_XOR, FUNC_SRL, FUNC_SRA, FUNC_OR, FUNC_AND,
      FUNC_BEQ, FUNC_BNE, FUNC_BLT, FUNC_BGE, FUNC_BLTU, FUNC_BGEU,
      FUNC_LB, FUNC_LH, FUNC_LW, FUNC_LBU, FUNC_LHU,
      FUNC_SB, FUNC_SH, FUNC_SW
   } fu_func_t;

   typedef struct packed {
      fu_op_t    fu_op;
      fu_t       fu;
      fu_func_t  fu_func;
      logic [XLEN-1:0] imm;
      reg_idx_t  rs1;
      reg_idx_t  rs2;
      reg_idx_t  rd;
      logic      rd_wen;
   } id_info_t;

   typedef struct packed {
      pc_t      pc;
      id_info_t info;
      logic     illegal;
   } id_entry_t;

   typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} idu_state_t;

endpackage

// File: rtl/idu_decoder.sv
// Combinational RV32I decoder: raw instruction word to id_info_t plus illegal flag.
module idu_decoder
   import liang_pkg::*;
(
   input  logic [31:0] inst,
   output id_info_t    info_c,
   output logic        illegal_c
);

   logic [6:0]      opcode;
   logic [2:0]      f3;
   logic [6:0]      f7;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign opcode = inst[6:0];
   assign f3     = inst[14:12];
   assign f7     = inst[31:25];
   assign imm_i  = {{20{inst[31]}}, inst[31:20]};
   assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
   assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign imm_u  = {inst[31:12], 12'b0};
   assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

   fu_op_t          op;
   fu_t             fu;
   fu_func_t        fn;
   logic [XLEN-1:0] imm;
   logic            use_rs1, use_rs2, writer, bad;

   always_comb begin
      op      = OP_NONE;
      fu      = FU_NONE;
      fn      = FUNC_NONE;
      imm     = '0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      writer  = 1'b0;
      bad     = 1'b0;
      case (opcode)
         OPC_OP: begin
            op = OP_ALR; fu = FU_ALU; use_rs1 = 1'b1; use_rs2 = 1'b1; writer = 1'b1;
            if (f7 == F7_ZERO) begin
               case (f3)
                  3'b000:  fn = FUNC_ADD;
                  3'b001:  fn = FUNC_SLL;
                  3'b010:  fn = FUNC_SLT;
                  3'b011:  fn = FUNC_SLTU;
                  3'b100:  fn = FUNC_XOR;
                  3'b101:  fn = FUNC_SRL;
                  3'b110:  fn = FUNC_OR;
                  default: fn = FUNC_AND;
               endcase
            end else if (f7 == F7_ALT && f3 == 3'b000) begin
               fn = FUNC_SUB;
            end else if (f7 == F7_ALT && f3 == 3'b101) begin
               fn = FUNC_SRA;
            end else begin
               bad = 1'b1;
            end
         end
         OPC_OPIMM: begin
            op = OP_ALI; fu = FU_ALU; use_rs1 = 1'b1; writer = 1'b1; imm = imm_i;
            case (f3)
               3'b000:  fn = FUNC_ADD;
               3'b010:  fn = FUNC_SLT;
               3'b011:  fn = FUNC_SLTU;
               3'b100:  fn = FUNC_XOR;
               3'b110:  fn = FUNC_OR;
               3'b111:  fn = FUNC_AND;
               3'b001:  if (f7 == F7_ZERO) fn = FUNC_SLL; else bad = 1'b1;
               default: begin
                  if (f7 == F7_ZERO)     fn = FUNC_SRL;
                  else if (f7 == F7_ALT) fn = FUNC_SRA;
                  else                   bad = 1'b1;
               end
            endcase
         end
         OPC_BRANCH: begin
            op = OP_BRANCH; fu = FU_ALU; use_rs1 = 1'b1; use_rs2 = 1'b1; imm = imm_b;
            case (f3)
               3'b000:  fn = FUNC_BEQ;
               3'b001:  fn = FUNC_BNE;
               3'b100:  fn = FUNC_BLT;
               3'b101:  fn = FUNC_BGE;
               3'b110:  fn = FUNC_BLTU;
               3'b111:  fn = FUNC_BGEU;
               default: bad = 1'b1;
            endcase
         end
         OPC_LOAD: begin
            op = OP_LOAD; fu = FU_LSU; use_rs1 = 1'b1; writer = 1'b1; imm = imm_i;
            case (f3)
               3'b000:  fn = FUNC_LB;
               3'b001:  fn = FUNC_LH;
               3'b010:  fn = FUNC_LW;
               3'b100:  fn = FUNC_LBU;
               3'b101:  fn = FUNC_LHU;
               default: bad = 1'b1;
            endcase
         end
         OPC_STORE: begin
            op = OP_STORE; fu = FU_LSU; use_rs1 = 1'b1; use_rs2 = 1'b1; imm = imm_s;
            case (f3)
               3'b000:  fn = FUNC_SB;
               3'b001:  fn = FUNC_SH;
               3'b010:  fn = FUNC_SW;
               default: bad = 1'b1;
            endcase
         end
         OPC_JAL: begin
            op = OP_JAL; fu = FU_ALU; writer = 1'b1; imm = imm_j;
         end
         OPC_JALR: begin
            op = OP_JALR; fu = FU_ALU; use_rs1 = 1'b1; writer = 1'b1; imm = imm_i;
            bad = (f3 != 3'b000);
         end
         OPC_AUIPC: begin
            op = OP_AUIPC; fu = FU_ALU; writer = 1'b1; imm = imm_u;
         end
         OPC_LUI: begin
            op = OP_LUI; fu = FU_ALU; writer = 1'b1; imm = imm_u;
         end
         default: bad = 1'b1;
      endcase
   end

   // Illegal instructions collapse to an all-zero record so downstream sees OP_NONE.
   always_comb begin
      info_c    = '0;
      illegal_c = bad;
      if (!bad) begin
         info_c.fu_op   = op;
         info_c.fu      = fu;
         info_c.fu_func = fn;
         info_c.imm     = imm;
         info_c.rs1     = use_rs1 ? inst[19:15] : '0;
         info_c.rs2     = use_rs2 ? inst[24:20] : '0;
         info_c.rd      = writer  ? inst[11:7]  : '0;
         info_c.rd_wen  = writer && (inst[11:7] != '0);
      end
   end

endmodule

// File: rtl/idu.sv
// Instruction-decode stage: decoder in front of a 2-entry skid buffer with registered ready.
module idu
   import liang_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            if_valid,
   output logic            if_ready,
   input  logic [XLEN-1:0] if_pc,
   input  logic [31:0]     if_inst,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] id_pc,
   output id_info_t        id_info,
   output logic            id_illegal
);

   id_info_t   dec_info;
   logic       dec_illegal;
   id_entry_t  in_entry;

   idu_decoder u_dec (
      .inst      (if_inst),
      .info_c    (dec_info),
      .illegal_c (dec_illegal)
   );

   assign in_entry = '{pc: if_pc, info: dec_info, illegal: dec_illegal};

   idu_state_t state_q, state_d;
   id_entry_t  m_q, m_d, s_q, s_d;
   logic       id_valid_q, id_valid_d;
   logic       if_ready_q, if_ready_d;
   logic       accept, drain;

   assign accept = if_valid && if_ready_q && !flush;
   assign drain  = id_valid_q && id_ready;

   // M always holds the oldest entry; S only fills when M is stalled.
   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      s_d     = s_q;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               m_d     = in_entry;
               state_d = ST_ONE;
            end
         end
         ST_ONE: begin
            if (accept && drain) begin
               m_d = in_entry;
            end else if (accept) begin
               s_d     = in_entry;
               state_d = ST_FULL;
            end else if (drain) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (drain) begin
               m_d     = s_q;
               state_d = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      if (flush) state_d = ST_EMPTY;
      id_valid_d = (state_d != ST_EMPTY);
      if_ready_d = (state_d != ST_FULL);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_EMPTY;
         m_q        <= '0;
         s_q        <= '0;
         id_valid_q <= 1'b0;
         if_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         m_q        <= m_d;
         s_q        <= s_d;
         id_valid_q <= id_valid_d;
         if_ready_q <= if_ready_d;
      end
   end

   assign if_ready   = if_ready_q;
   assign id_valid   = id_valid_q;
   assign id_pc      = m_q.pc;
   assign id_info    = m_q.info;
   assign id_illegal = m_q.illegal;

endmodule

// File: tb/tb_idu.sv
// Directed bench for idu: decode vectors, backpressure, flush, async reset, random handshake.
module tb_idu;
   import liang_pkg::*;

   logic            clk, rst, flush, if_valid, if_ready, id_valid, id_ready, id_illegal;
   logic [XLEN-1:0] if_pc, id_pc;
   logic [31:0]     if_inst;
   id_info_t        id_info;

   idu dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .if_valid   (if_valid),
      .if_ready   (if_ready),
      .if_pc      (if_pc),
      .if_inst    (if_inst),
      .id_valid   (id_valid),
      .id_ready   (id_ready),
      .id_pc      (id_pc),
      .id_info    (id_info),
      .id_illegal (id_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int n_drained = 0;
   logic last_acc;

   localparam int unsigned NVEC = 9;
   inst_t    tbl_inst [NVEC];
   id_info_t tbl_info [NVEC];
   logic     tbl_ill  [NVEC];

   // Reference queue of accepted entries: pc and table index.
   logic [31:0] q_pc [$];
   int          q_k  [$];

   function automatic id_info_t mk(input fu_op_t op, input fu_t fu, input fu_func_t fn,
                                   input logic [31:0] imm, input logic [4:0] rs1,
                                   input logic [4:0] rs2, input logic [4:0] rd, input logic wen);
      id_info_t i;
      i.fu_op = op; i.fu = fu; i.fu_func = fn; i.imm = imm;
      i.rs1 = rs1; i.rs2 = rs2; i.rd = rd; i.rd_wen = wen;
      return i;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive at negedge, check outputs against the queue model, advance the model.
   task automatic cycle(input logic v, input logic r, input logic [31:0] pc, input int k);
      logic acc, drn;
      @(negedge clk);
      flush = 1'b0; if_valid = v; id_ready = r; if_pc = pc; if_inst = tbl_inst[k];
      check("id_valid", 64'(id_valid), 64'(q_pc.size() > 0));
      check("if_ready", 64'(if_ready), 64'(q_pc.size() < 2));
      if (q_pc.size() > 0) begin
         check("id_pc",      64'(id_pc),      64'(q_pc[0]));
         check("id_info",    64'(id_info),    64'(tbl_info[q_k[0]]));
         check("id_illegal", 64'(id_illegal), 64'(tbl_ill[q_k[0]]));
      end
      acc = v && (q_pc.size() < 2);
      drn = r && (q_pc.size() > 0);
      if (drn) begin
         void'(q_pc.pop_front());
         void'(q_k.pop_front());
         n_drained++;
      end
      if (acc) begin
         q_pc.push_back(pc);
         q_k.push_back(k);
      end
      last_acc = acc;
   endtask

   initial begin
      logic [31:0] nxt;
      tbl_inst[0] = 32'h00500093; tbl_info[0] = mk(OP_ALI, FU_ALU, FUNC_ADD, 32'd5, 5'd0, 5'd0, 5'd1, 1'b1);    tbl_ill[0] = 1'b0;
      tbl_inst[1] = 32'hFE208CE3; tbl_info[1] = mk(OP_BRANCH, FU_ALU, FUNC_BEQ, 32'hFFFFFFF8, 5'd1, 5'd2, 5'd0, 1'b0); tbl_ill[1] = 1'b0;
      tbl_inst[2] = 32'h0020A623; tbl_info[2] = mk(OP_STORE, FU_LSU, FUNC_SW, 32'd12, 5'd1, 5'd2, 5'd0, 1'b0);   tbl_ill[2] = 1'b0;
      tbl_inst[3] = 32'hFFFFFFFF; tbl_info[3] = '0; tbl_ill[3] = 1'b1;
      tbl_inst[4] = 32'h02208033; tbl_info[4] = '0; tbl_ill[4] = 1'b1;
      tbl_inst[5] = 32'h00000013; tbl_info[5] = mk(OP_ALI, FU_ALU, FUNC_ADD, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0);     tbl_ill[5] = 1'b0;
      tbl_inst[6] = 32'hFFC12283; tbl_info[6] = mk(OP_LOAD, FU_LSU, FUNC_LW, 32'hFFFFFFFC, 5'd2, 5'd0, 5'd5, 1'b1); tbl_ill[6] = 1'b0;
      tbl_inst[7] = 32'h123451B7; tbl_info[7] = mk(OP_LUI, FU_ALU, FUNC_NONE, 32'h12345000, 5'd0, 5'd0, 5'd3, 1'b1); tbl_ill[7] = 1'b0;
      tbl_inst[8] = 32'h4030D093; tbl_info[8] = mk(OP_ALI, FU_ALU, FUNC_SRA, 32'h00000403, 5'd1, 5'd0, 5'd1, 1'b1); tbl_ill[8] = 1'b0;

      rst = 1'b1; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0; if_pc = '0; if_inst = '0;
      @(negedge clk);
      check("rst_id_valid", 64'(id_valid), 64'(0));
      check("rst_if_ready", 64'(if_ready), 64'(1));
      check("rst_id_pc",    64'(id_pc),    64'(0));
      check("rst_id_info",  64'(id_info),  64'(0));
      rst = 1'b0;

      // Decode vectors, one at a time with id_ready high.
      for (int k = 0; k < int'(NVEC); k++) begin
         cycle(1'b1, 1'b1, 32'(32'h1000 + 4 * k), k);
         cycle(1'b0, 1'b1, 32'h0, 0);
      end

      // Backpressure: stream with id_ready low in cycles 2..5.
      n_drained = 0;
      nxt = 32'h0;
      for (int c = 0; c < 12; c++) begin
         cycle(1'b1, !(c >= 2 && c <= 5), nxt, c % int'(NVEC));
         check("bp_if_ready", 64'(if_ready), 64'((c >= 3 && c <= 6) ? 0 : 1));
         if (last_acc) nxt = nxt + 32'd4;
      end
      for (int c = 0; c < 3; c++) cycle(1'b0, 1'b1, 32'h0, 0);
      check("bp_drained", 64'(n_drained), 64'(8));

      // Flush while FULL with a simultaneous incoming instruction.
      cycle(1'b1, 1'b0, 32'h100, 0);
      cycle(1'b1, 1'b0, 32'h104, 1);
      @(negedge clk);
      flush = 1'b1; if_valid = 1'b1; id_ready = 1'b0; if_pc = 32'h108; if_inst = tbl_inst[2];
      check("fl_if_ready_full", 64'(if_ready), 64'(0));
      check("fl_id_pc_head",    64'(id_pc),    64'(32'h100));
      q_pc.delete(); q_k.delete();
      cycle(1'b0, 1'b1, 32'h0, 0);
      cycle(1'b1, 1'b1, 32'h200, 7);
      cycle(1'b0, 1'b1, 32'h0, 0);
      check("fl_after_pc", 64'(id_pc), 64'(32'h200));

      // Asynchronous reset between edges.
      cycle(1'b1, 1'b0, 32'h300, 6);
      @(negedge clk);
      if_valid = 1'b0; id_ready = 1'b0;
      check("ar_pre_pc", 64'(id_pc), 64'(32'h300));
      #2 rst = 1'b1;
      #1;
      check("ar_id_valid",   64'(id_valid),   64'(0));
      check("ar_if_ready",   64'(if_ready),   64'(1));
      check("ar_id_pc",      64'(id_pc),      64'(0));
      check("ar_id_info",    64'(id_info),    64'(0));
      check("ar_id_illegal", 64'(id_illegal), 64'(0));
      q_pc.delete(); q_k.delete();
      @(posedge clk);
      #2 rst = 1'b0;
      cycle(1'b1, 1'b1, 32'h304, 0);
      cycle(1'b0, 1'b0, 32'h0, 0);
      check("ar_first_pc", 64'(id_pc), 64'(32'h304));
      cycle(1'b0, 1'b1, 32'h0, 0);

      // Random valid/ready on both sides.
      nxt = 32'h8000;
      for (int c = 0; c < 10000; c++) begin
         cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), nxt, int'($urandom_range(0, NVEC - 1)));
         if (last_acc) nxt = nxt + 32'd4;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
